// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: four-digit multiplexed 7-segment driver.
// Digits and decimal points are captured into shadow registers on load and
// scanned out one digit per slot. An optional leading-zero blanking mode
// darkens zero digits above the most significant non-zero digit.
// All display outputs are active-low and registered.

module bcd_seg_scan #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Segment patterns are active-low, ordered gfedcba.
    // Codes above 9 are not valid BCD and are shown as a single dash.
    function automatic logic [6:0] f_bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_digits;
    logic [3:0]       r_dp_sh;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_tick;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [3:0]       w_an;
    logic [6:0]       w_seg;
    logic             w_dp;

    assign w_tick = (r_cnt == CNT_MAX);

    // Prescaler and scan index: each digit owns REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_idx <= r_idx;
        end
    end

    // Shadow registers decouple the display from the upstream counter chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 16'h0000;
            r_dp_sh  <= 4'h0;
        end else if (load) begin
            r_digits <= digits_in;
            r_dp_sh  <= dp_in;
        end else begin
            r_digits <= r_digits;
            r_dp_sh  <= r_dp_sh;
        end
    end

    // Select the current digit and decide whether it is a leading zero.
    // Invalid BCD codes are non-zero, so they stop blanking naturally.
    always_comb begin
        w_digit = 4'h0;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit = r_digits[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = r_digits[7:4];
                w_blank = blank_lz && (r_digits[15:4] == 12'h000);
            end
            2'd2: begin
                w_digit = r_digits[11:8];
                w_blank = blank_lz && (r_digits[15:8] == 8'h00);
            end
            2'd3: begin
                w_digit = r_digits[15:12];
                w_blank = blank_lz && (r_digits[15:12] == 4'h0);
            end
            default: begin
                w_digit = 4'h0;
                w_blank = 1'b0;
            end
        endcase
    end

    // Next display values; a blanked slot keeps everything dark.
    always_comb begin
        w_an  = 4'hF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (w_blank) begin
            w_an  = 4'hF;
            w_seg = 7'h7F;
            w_dp  = 1'b1;
        end else begin
            w_an  = ~(4'b0001 << r_idx);
            w_seg = f_bcd_to_seg(w_digit);
            w_dp  = ~r_dp_sh[r_idx];
        end
    end

    // Output registers give glitch-free pad drive with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
